riscv_test_monitor: RTL

Host-side responder for the riscv-tests completion protocol in the simulation environment. It snoops the core's data-memory write port and decodes the test program's `tohost` writes into sticky pass, fail and timeout status. It also captures bytes written to a console address into a small FIFO so a bench can drain them. It is instantiated next to `Core` in each per-test bench, and its `halt` output lets the bench stop on completion instead of always running the full tick count.

---
 rtl/riscv_test_monitor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/riscv_test_monitor.sv
// riscv-tests completion monitor: decodes tohost writes into sticky pass/fail/timeout
// status, counts RUN cycles, and buffers console bytes in a small FIFO.
module riscv_test_monitor #(
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000,
  parameter logic [31:0] CONSOLE_ADDR = 32'h0000_1004,
  parameter int unsigned TIMEOUT      = 5000,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic        halt,
  output logic [30:0] test_num,
  output logic [31:0] cycles,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        con_overflow
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TMO  = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] cycles_r;
  logic [30:0] test_num_r;
  logic        tohost_done_s;

  // Only odd full-word tohost writes signal completion; even values are syscalls.
  assign tohost_done_s = wr_en && (wr_addr == TOHOST_ADDR) && (wr_strb == 4'hF) && wr_data[0];

  // Next-state logic: completion write takes priority over timeout expiry.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (tohost_done_s) begin
          if (wr_data == 32'd1) begin
            state_nxt_s = ST_PASS;
          end else begin
            state_nxt_s = ST_FAIL;
          end
        end else if (cycles_r == TMO_LAST) begin
          state_nxt_s = ST_TMO;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_PASS, ST_FAIL, ST_TMO: state_nxt_s = state_r;
      default:                  state_nxt_s = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Saturating RUN-cycle counter; frozen once a terminal state is entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycles_r <= 32'd0;
    end else if ((state_r == ST_RUN) && (cycles_r != 32'hFFFF_FFFF)) begin
      cycles_r <= cycles_r + 32'd1;
    end
  end

  // Failing test number latch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      test_num_r <= 31'd0;
    end else if ((state_r == ST_RUN) && (state_nxt_s == ST_FAIL)) begin
      test_num_r <= wr_data[31:1];
    end
  end

  assign pass     = (state_r == ST_PASS);
  assign fail     = (state_r == ST_FAIL);
  assign timeout  = (state_r == ST_TMO);
  assign done     = pass | fail | timeout;
  assign halt     = done;
  assign test_num = test_num_r;
  assign cycles   = cycles_r;

  logic [7:0]  mem_r [FIFO_DEPTH];
  logic [AW:0] wptr_r, rptr_r;
  logic        overflow_r;
  logic        empty_s, full_s, pop_s, push_req_s, push_s;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_s    = (wptr_r == rptr_r);
  assign full_s     = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign pop_s      = con_ready && !empty_s;
  assign push_req_s = wr_en && (wr_addr == CONSOLE_ADDR) && wr_strb[0];
  assign push_s     = push_req_s && (!full_s || pop_s);

  // Console byte storage.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      mem_r[wptr_r[AW-1:0]] <= wr_data[7:0];
    end
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + 1'b1;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + 1'b1;
      end
      if (push_req_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign con_valid    = !empty_s;
  assign con_data     = empty_s ? 8'h00 : mem_r[rptr_r[AW-1:0]];
  assign con_overflow = overflow_r;

endmodule
